pwm_capture: RTL and testbench

//  Receive-side counterpart of the square/PWM generators: measures an incoming PWM line.
//  Per full period it reports high time and period in sysclk cycles, with a one-cycle valid strobe.

---
 rtl/pwm_pkg.sv | 22 ++
 rtl/pwm_sync_edge.sv | 76 +++++++
 rtl/pwm_capture.sv | 143 ++++++++++++++
 tb/tb_pwm_capture.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// ============================================================================
//  Module  : pwm_pkg
//  Brief   : Shared PWM types and the default counter width for capture and
//            generator blocks.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package pwm_pkg;

  localparam int CNT_W_DEF = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HIGH  = 2'd1,
    LOW   = 2'd2,
    STUCK = 2'd3
  } pwm_state_t;

endpackage

`default_nettype wire

// File: rtl/pwm_sync_edge.sv
// ============================================================================
//  Module  : pwm_sync_edge
//  Brief   : 2-FF synchronizer, optional stable-level deglitch
//            (PWM_DEGLITCH_EN), and single-cycle rise/fall pulses.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module pwm_sync_edge #(
  parameter int FILT_LEN = 3
) (
  input  logic sysclk,
  input  logic sys_rst_n,
  input  logic pwm_in,
  output logic rise,
  output logic fall
);

`ifdef PWM_DEGLITCH_EN
  localparam bit c_filt_en = 1'b1;
`else
  localparam bit c_filt_en = 1'b0;
`endif

  logic [1:0] r_sync;
  logic       r_prev;
  logic       w_level;

  always_ff @(posedge sysclk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_sync <= 2'b00;
    end else begin
      r_sync <= {r_sync[0], pwm_in};
    end
  end

  generate
    if (c_filt_en) begin : g_filt
      logic [FILT_LEN-1:0] r_hist;
      logic                r_filt;

      // Level only moves once FILT_LEN consecutive samples agree.
      always_ff @(posedge sysclk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
          r_hist <= '0;
          r_filt <= 1'b0;
        end else begin
          r_hist <= (r_hist << 1) | FILT_LEN'(r_sync[1]);
          if (&r_hist) begin
            r_filt <= 1'b1;
          end else if (~|r_hist) begin
            r_filt <= 1'b0;
          end
        end
      end

      assign w_level = r_filt;
    end else begin : g_nofilt
      assign w_level = r_sync[1];
    end
  endgenerate

  always_ff @(posedge sysclk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_prev <= 1'b0;
    end else begin
      r_prev <= w_level;
    end
  end

  assign rise = w_level & ~r_prev;
  assign fall = ~w_level & r_prev;

endmodule

`default_nettype wire

// File: rtl/pwm_capture.sv
// ============================================================================
//  Module  : pwm_capture
//  Brief   : Measures high time and period of an asynchronous PWM line and
//            flags stuck-high / stuck-low; deglitch via PWM_DEGLITCH_EN.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module pwm_capture
  import pwm_pkg::*;
#(
  parameter int CNT_W    = CNT_W_DEF,
  parameter int FILT_LEN = 3
) (
  input  logic             sysclk,
  input  logic             sys_rst_n,
  input  logic             enable,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] high_cnt,
  output logic [CNT_W-1:0] period_cnt,
  output logic             meas_valid,
  output logic             stuck_hi,
  output logic             stuck_lo
);

  localparam logic [CNT_W-1:0] c_cnt_max = '1;
  localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

  logic w_rise, w_fall;

  pwm_sync_edge #(
    .FILT_LEN (FILT_LEN)
  ) u_sync_edge (
    .sysclk    (sysclk),
    .sys_rst_n (sys_rst_n),
    .pwm_in    (pwm_in),
    .rise      (w_rise),
    .fall      (w_fall)
  );

  pwm_state_t       r_state, w_state_nxt;
  logic [CNT_W-1:0] r_per_c, w_per_nxt, r_hi_c, w_hi_nxt;
  logic [CNT_W-1:0] r_high_cnt, w_high_nxt, r_period_cnt, w_period_nxt;
  logic [CNT_W-1:0] w_per_inc, w_hi_inc;
  logic             r_valid, w_valid_nxt;
  logic             r_stuck_hi, w_stuck_hi_nxt, r_stuck_lo, w_stuck_lo_nxt;

  assign w_per_inc = (r_per_c == c_cnt_max) ? r_per_c : r_per_c + c_cnt_one;
  assign w_hi_inc  = (r_hi_c  == c_cnt_max) ? r_hi_c  : r_hi_c  + c_cnt_one;

  always_comb begin
    w_state_nxt    = r_state;
    w_per_nxt      = r_per_c;
    w_hi_nxt       = r_hi_c;
    w_high_nxt     = r_high_cnt;
    w_period_nxt   = r_period_cnt;
    w_valid_nxt    = 1'b0;
    w_stuck_hi_nxt = r_stuck_hi;
    w_stuck_lo_nxt = r_stuck_lo;

    if (!enable) begin
      w_state_nxt    = IDLE;
      w_per_nxt      = '0;
      w_hi_nxt       = '0;
      w_stuck_hi_nxt = 1'b0;
      w_stuck_lo_nxt = 1'b0;
    end else begin
      case (r_state)
        IDLE, STUCK: begin
          // A rise here only opens a period; nothing is reported for it.
          if (w_rise) begin
            w_state_nxt = HIGH;
            w_per_nxt   = c_cnt_one;
            w_hi_nxt    = c_cnt_one;
          end
        end
        HIGH: begin
          if (w_fall) begin
            w_state_nxt = LOW;
            w_per_nxt   = w_per_inc;
          end else if (r_per_c == c_cnt_max) begin
            w_state_nxt    = STUCK;
            w_stuck_hi_nxt = 1'b1;
            w_stuck_lo_nxt = 1'b0;
          end else begin
            w_per_nxt = w_per_inc;
            w_hi_nxt  = w_hi_inc;
          end
        end
        LOW: begin
          if (w_rise) begin
            w_state_nxt    = HIGH;
            w_high_nxt     = r_hi_c;
            w_period_nxt   = r_per_c;
            w_valid_nxt    = 1'b1;
            w_stuck_hi_nxt = 1'b0;
            w_stuck_lo_nxt = 1'b0;
            w_per_nxt      = c_cnt_one;
            w_hi_nxt       = c_cnt_one;
          end else if (r_per_c == c_cnt_max) begin
            w_state_nxt    = STUCK;
            w_stuck_lo_nxt = 1'b1;
            w_stuck_hi_nxt = 1'b0;
          end else begin
            w_per_nxt = w_per_inc;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge sysclk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state      <= IDLE;
      r_per_c      <= '0;
      r_hi_c       <= '0;
      r_high_cnt   <= '0;
      r_period_cnt <= '0;
      r_valid      <= 1'b0;
      r_stuck_hi   <= 1'b0;
      r_stuck_lo   <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_per_c      <= w_per_nxt;
      r_hi_c       <= w_hi_nxt;
      r_high_cnt   <= w_high_nxt;
      r_period_cnt <= w_period_nxt;
      r_valid      <= w_valid_nxt;
      r_stuck_hi   <= w_stuck_hi_nxt;
      r_stuck_lo   <= w_stuck_lo_nxt;
    end
  end

  assign high_cnt   = r_high_cnt;
  assign period_cnt = r_period_cnt;
  assign meas_valid = r_valid;
  assign stuck_hi   = r_stuck_hi;
  assign stuck_lo   = r_stuck_lo;

endmodule

`default_nettype wire

// File: tb/tb_pwm_capture.sv
// ============================================================================
//  Module  : tb_pwm_capture
//  Brief   : Scoreboard bench for pwm_capture at CNT_W=6 and CNT_W=7 sharing
//            one PWM line; PWM_DEGLITCH_EN selects the glitch expectations.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pwm_capture;

  logic sysclk    = 1'b0;
  logic sys_rst_n = 1'b0;
  logic enable    = 1'b0;
  logic pwm_in    = 1'b0;

  always #5 sysclk = ~sysclk;

  logic [5:0] hi6, per6;
  logic       v6, sh6, sl6;
  logic [6:0] hi7, per7;
  logic       v7, sh7, sl7;

  pwm_capture #(.CNT_W(6), .FILT_LEN(3)) u_dut6 (
    .sysclk     (sysclk),
    .sys_rst_n  (sys_rst_n),
    .enable     (enable),
    .pwm_in     (pwm_in),
    .high_cnt   (hi6),
    .period_cnt (per6),
    .meas_valid (v6),
    .stuck_hi   (sh6),
    .stuck_lo   (sl6)
  );

  pwm_capture #(.CNT_W(7), .FILT_LEN(3)) u_dut7 (
    .sysclk     (sysclk),
    .sys_rst_n  (sys_rst_n),
    .enable     (enable),
    .pwm_in     (pwm_in),
    .high_cnt   (hi7),
    .period_cnt (per7),
    .meas_valid (v7),
    .stuck_hi   (sh7),
    .stuck_lo   (sl7)
  );

  typedef struct {
    int hi;
    int per;
  } exp_t;

  exp_t q6[$];
  exp_t q7[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected report for one closed period, routed to each width that can measure it.
  task automatic push_both(input int h, input int p);
    exp_t e;
    e.hi  = h;
    e.per = p;
    if (p <= 63)  q6.push_back(e);
    if (p <= 127) q7.push_back(e);
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge sysclk);
      #1;
    end
  endtask

  task automatic pulse(input int h, input int l);
    pwm_in = 1'b1;
    cyc(h);
    pwm_in = 1'b0;
    cyc(l);
  endtask

  task automatic train(input int h, input int l, input int n);
    for (int i = 0; i < n; i++) begin
      if (i > 0) push_both(h, h + l);
      pulse(h, l);
    end
  endtask

  logic pv6 = 1'b0;
  logic pv7 = 1'b0;

  always @(negedge sysclk) begin
    exp_t e;
    if (v6) begin
      check("dut6 valid back-to-back", pv6, 1'b0);
      check("dut6 report expected", q6.size() != 0, 1'b1);
      if (q6.size() != 0) begin
        e = q6.pop_front();
        check("dut6 high_cnt", hi6, e.hi);
        check("dut6 period_cnt", per6, e.per);
      end
    end
    pv6 = v6;
  end

  always @(negedge sysclk) begin
    exp_t e;
    if (v7) begin
      check("dut7 valid back-to-back", pv7, 1'b0);
      check("dut7 report expected", q7.size() != 0, 1'b1);
      if (q7.size() != 0) begin
        e = q7.pop_front();
        check("dut7 high_cnt", hi7, e.hi);
        check("dut7 period_cnt", per7, e.per);
      end
    end
    pv7 = v7;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    cyc(3);
    check("reset high_cnt", hi6, 0);
    check("reset period_cnt", per6, 0);
    check("reset meas_valid", v6, 0);
    check("reset stuck_hi", sh6, 0);
    check("reset stuck_lo", sl6, 0);
    sys_rst_n = 1'b1;
    enable    = 1'b1;

    // Line low since reset: IDLE must not flag stuck_lo.
    cyc(100);
    check("idle stuck_lo dut6", sl6, 0);
    check("idle stuck_lo dut7", sl7, 0);

    // 5/20 PWM.
    train(5, 15, 4);
    check("5/20 stuck_hi", sh6, 0);
    check("5/20 stuck_lo", sl6, 0);
    cyc(130);
    check("held low stuck_lo dut6", sl6, 1);
    check("held low stuck_lo dut7", sl7, 1);
    check("stuck keeps period_cnt", per6, 20);

    // Dropping enable clears stuck flags but keeps the last measurement.
    enable = 1'b0;
    cyc(2);
    check("enable off stuck_lo", sl6, 0);
    check("enable off high_cnt", hi6, 5);
    check("enable off period_cnt", per6, 20);
    enable = 1'b1;
    cyc(5);

    // 32/64 PWM: measurable only at CNT_W=7; CNT_W=6 saturates every period.
    train(32, 32, 4);
    check("64 period dut6 unchanged", per6, 20);
    cyc(130);

    // Held high 100 cycles, then a clean 10/30 train.
    pwm_in = 1'b1;
    cyc(50);
    check("high 50 stuck_hi dut6", sh6, 0);
    cyc(40);
    check("high 90 stuck_hi dut6", sh6, 1);
    check("high 90 stuck_hi dut7", sh7, 0);
    cyc(10);
    pwm_in = 1'b0;
    cyc(10);
    push_both(100, 110);
    train(10, 20, 3);
    check("stuck_hi cleared by report", sh6, 0);
    cyc(130);

    // Async reset in the middle of a high phase.
    pwm_in = 1'b1;
    cyc(10);
    sys_rst_n = 1'b0;
    pwm_in    = 1'b0;
    #1;
    check("async rst high_cnt", hi6, 0);
    check("async rst period_cnt", per6, 0);
    check("async rst stuck_lo", sl6, 0);
    check("async rst dut7 high_cnt", hi7, 0);
    cyc(4);
    sys_rst_n = 1'b1;
    cyc(5);
    train(10, 20, 4);
    cyc(130);

    // 20-high pulse carrying a 2-cycle low glitch.
    pulse(20, 10);
    push_both(20, 30);
`ifdef PWM_DEGLITCH_EN
    push_both(20, 30);
`else
    push_both(8, 10);
    push_both(10, 20);
`endif
    pulse(8, 2);
    pulse(10, 10);
    pulse(20, 10);
    cyc(130);

    cyc(20);
    check("dut6 reports outstanding", q6.size(), 0);
    check("dut7 reports outstanding", q7.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
